// File: rtl/shift_reg_serializer_if.sv
// shift_reg_serializer_if: byte handshake in, serial bit stream and LED status out.
interface shift_reg_serializer_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       frame_start;
  logic [2:0] LED;
  modport master (output data, data_valid, input data_ready, ser_out, ser_valid, frame_start, LED);
  modport slave (input data, data_valid, output data_ready, ser_out, ser_valid, frame_start, LED);
endinterface

// File: rtl/shift_reg_serializer.sv
// shift_reg_serializer: byte-in, bit-per-clock serializer with one-byte holding buffer.
module shift_reg_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  shift_reg_serializer_if.slave  bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t     state;
  logic [7:0] hold_reg, shift_reg, shifted;
  logic [2:0] counter;
  logic       hold_full, ser_out, ser_valid, frame_start, done_toggle;
  logic       last, load, next_bit;
  assign last     = state == SHIFT && counter == 3'd7;
  assign load     = hold_full && (state == IDLE || last);
  assign shifted  = MSB_FIRST ? {shift_reg[6:0], 1'b0} : {1'b0, shift_reg[7:1]};
  assign next_bit = MSB_FIRST ? shift_reg[6] : shift_reg[1];
  assign bus.data_ready  = rst_n && !hold_full;
  assign bus.ser_out     = ser_out;
  assign bus.ser_valid   = ser_valid;
  assign bus.frame_start = frame_start;
  assign bus.LED         = {ser_valid, hold_full, done_toggle};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      counter     <= 3'd0;
      shift_reg   <= 8'd0;
      hold_reg    <= 8'd0;
      hold_full   <= 1'b0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      done_toggle <= 1'b0;
    end else begin
      if (bus.data_valid && !hold_full) begin
        hold_reg  <= bus.data;
        hold_full <= 1'b1;
      end
      if (load) begin
        shift_reg   <= hold_reg;
        counter     <= 3'd0;
        hold_full   <= 1'b0;
        state       <= SHIFT;
        ser_valid   <= 1'b1;
        frame_start <= 1'b1;
        ser_out     <= MSB_FIRST ? hold_reg[7] : hold_reg[0];
      end else if (state == SHIFT && !last) begin
        counter     <= counter + 3'd1;
        shift_reg   <= shifted;
        ser_out     <= next_bit;
        frame_start <= 1'b0;
      end else if (last) begin
        state       <= IDLE;
        counter     <= 3'd0;
        ser_valid   <= 1'b0;
        frame_start <= 1'b0;
        ser_out     <= 1'b0;
      end
      if (last) done_toggle <= ~done_toggle;
    end
  end
endmodule

// File: tb/tb_shift_reg_serializer.sv
// tb_shift_reg_serializer: directed steps with a per-bit scoreboard for MSB- and LSB-first instances.
module tb_shift_reg_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] qm[$];
  logic [1:0] ql[$];
  shift_reg_serializer_if m ();
  shift_reg_serializer_if l ();
  shift_reg_serializer #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(m));
  shift_reg_serializer #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(l));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push_byte(input bit msb, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (msb) qm.push_back({i == 0, b[7-i]});
      else ql.push_back({i == 0, b[i]});
    end
  endtask
  task automatic step();
    logic [1:0] e;
    @(posedge clk);
    #1;
    if (m.ser_valid === 1'b1) begin
      if (qm.size() == 0) chk("msb_unexpected_bit", 8'(m.ser_out), 8'hxx);
      else begin
        e = qm.pop_front();
        chk("msb_bit", 8'(m.ser_out), 8'(e[0]));
        chk("msb_frame", 8'(m.frame_start), 8'(e[1]));
      end
    end else chk("msb_idle_frame", 8'(m.frame_start), 8'd0);
    if (l.ser_valid === 1'b1) begin
      if (ql.size() == 0) chk("lsb_unexpected_bit", 8'(l.ser_out), 8'hxx);
      else begin
        e = ql.pop_front();
        chk("lsb_bit", 8'(l.ser_out), 8'(e[0]));
        chk("lsb_frame", 8'(l.frame_start), 8'(e[1]));
      end
    end else chk("lsb_idle_frame", 8'(l.frame_start), 8'd0);
  endtask
  initial begin
    m.data = 8'h33; m.data_valid = 1'b1;
    l.data = 8'h00; l.data_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 8'(m.data_ready), 8'd0);
      step();
    end
    chk("rst_ser_valid", 8'(m.ser_valid), 8'd0);
    chk("rst_led", 8'(m.LED), 8'd0);
    rst_n = 1'b1; m.data_valid = 1'b0;
    #1;
    chk("post_rst_ready", 8'(m.data_ready), 8'd1);
    chk("post_rst_led", 8'(m.LED), 8'd0);
    // single byte 0xA5, MSB first
    push_byte(1'b1, 8'hA5);
    m.data = 8'hA5; m.data_valid = 1'b1;
    step();
    m.data_valid = 1'b0;
    chk("a5_accept_ready", 8'(m.data_ready), 8'd0);
    chk("a5_accept_led", 8'(m.LED), 8'b010);
    chk("a5_accept_sv", 8'(m.ser_valid), 8'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("a5_sv", 8'(m.ser_valid), 8'd1);
    end
    step();
    chk("a5_done_sv", 8'(m.ser_valid), 8'd0);
    chk("a5_done_led", 8'(m.LED), 8'b001);
    chk("a5_done_out", 8'(m.ser_out), 8'd0);
    // back-to-back 0xFF, 0x00 from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    push_byte(1'b1, 8'hFF);
    push_byte(1'b1, 8'h00);
    m.data = 8'hFF; m.data_valid = 1'b1;
    step();
    m.data = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 2) m.data_valid = 1'b0;
      chk("b2b_sv", 8'(m.ser_valid), 8'd1);
      if (i == 1 || i == 9) chk("b2b_ready_open", 8'(m.data_ready), 8'd1);
      if (i >= 2 && i <= 8) chk("b2b_ready_held", 8'(m.data_ready), 8'd0);
      if (i == 9) chk("b2b_toggle1", 8'(m.LED[0]), 8'd1);
    end
    step();
    chk("b2b_end_sv", 8'(m.ser_valid), 8'd0);
    chk("b2b_end_led", 8'(m.LED), 8'd0);
    // LSB-first instance, byte 0x01
    push_byte(1'b0, 8'h01);
    l.data = 8'h01; l.data_valid = 1'b1;
    step();
    l.data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("lsb_sv", 8'(l.ser_valid), 8'd1);
    end
    step();
    chk("lsb_done_sv", 8'(l.ser_valid), 8'd0);
    chk("lsb_done_led", 8'(l.LED), 8'b001);
    // late second byte: accepted on the counter==7 edge leaves one gap cycle
    push_byte(1'b1, 8'h3C);
    push_byte(1'b1, 8'hC3);
    m.data = 8'h3C; m.data_valid = 1'b1;
    step();
    m.data_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    m.data = 8'hC3; m.data_valid = 1'b1;
    step();
    m.data_valid = 1'b0;
    chk("late_gap_sv", 8'(m.ser_valid), 8'd0);
    chk("late_gap_hold", 8'(m.LED[1]), 8'd1);
    step();
    chk("late_start_sv", 8'(m.ser_valid), 8'd1);
    chk("late_start_frame", 8'(m.frame_start), 8'd1);
    for (int i = 0; i < 7; i++) step();
    step();
    chk("late_end_sv", 8'(m.ser_valid), 8'd0);
    chk("late_end_led", 8'(m.LED), 8'd0);
    // reset at counter==4 with a byte held
    push_byte(1'b1, 8'h96);
    m.data = 8'h96; m.data_valid = 1'b1;
    step();
    m.data = 8'h5A;
    step();
    step();
    m.data_valid = 1'b0;
    chk("mid_hold_full", 8'(m.LED[1]), 8'd1);
    step(); step(); step();
    qm.delete();
    rst_n = 1'b0;
    step();
    chk("mid_rst_sv", 8'(m.ser_valid), 8'd0);
    chk("mid_rst_out", 8'(m.ser_out), 8'd0);
    chk("mid_rst_frame", 8'(m.frame_start), 8'd0);
    chk("mid_rst_led", 8'(m.LED), 8'd0);
    chk("mid_rst_ready", 8'(m.data_ready), 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mid_after_sv", 8'(m.ser_valid), 8'd0);
      chk("mid_after_led", 8'(m.LED), 8'd0);
    end
    chk("qm_drained", 8'(qm.size()), 8'd0);
    chk("ql_drained", 8'(ql.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_reg_serializer.md
# shift_reg_serializer

Transmit-side companion to the byte-sampling shift register / LED indicator path: accepts parallel bytes over a valid/ready handshake and emits them one bit per clock from an 8-bit shift register indexed by a 3-bit counter. A one-byte holding buffer lets back-to-back bytes leave with no idle bit between them. A 3-bit LED status vector reports activity for board-level debug.

## Interface
- MSB_FIRST, default 1: 1 = bit 7 transmitted first; 0 = bit 0 first.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous reset, active-low; sampled on clk rising edge.
- data  input  8  byte to transmit.
- data_valid  input  1  data is presented this cycle.
- data_ready  output  1  holding buffer can accept; transfer occurs on an edge where data_valid && data_ready.
- ser_out  output  1  current serial bit; registered.
- ser_valid  output  1  ser_out carries a payload bit this cycle; registered.
- frame_start  output  1  high during the first bit of each byte; registered.
- LED  output  3  {busy, hold_full, byte_done_toggle}; registered.

## Operation
- Internal state:
  - hold_reg[7:0] and hold_full.
  - shift_reg[7:0] and counter[2:0].
  - Two-state FSM: IDLE, SHIFT.
- data_ready = rst_n && !hold_full. Combinational from registered state only; no combinational path from data_valid.
- Accept: on an edge with data_valid && data_ready, hold_reg <= data and hold_full <= 1.
- Load condition: hold_full && (state == IDLE || (state == SHIFT && counter == 7)). On load:
  - shift_reg <= hold_reg and counter <= 0.
  - hold_full <= 0 (accept and load cannot coincide, because accept requires !hold_full).
  - state <= SHIFT; ser_valid <= 1; frame_start <= 1.
  - ser_out <= hold_reg[7] if MSB_FIRST, else hold_reg[0].
- SHIFT with counter != 7:
  - counter <= counter + 1.
  - shift_reg shifts left (MSB_FIRST) or right by one, zero-filled.
  - ser_out <= next bit; frame_start <= 0.
- SHIFT with counter == 7 (last bit on the wire):
  - LED[0] toggles.
  - If the load condition holds, the next byte loads on the same edge, giving a gapless stream.
  - Otherwise state <= IDLE, ser_valid <= 0, frame_start <= 0, and ser_out <= 0.
- The counter is 3 bits and wraps 7 -> 0 only through a load. In IDLE it holds 0.
- LED bits:
  - LED[2] = ser_valid.
  - LED[1] = hold_full.
  - LED[0] = byte_done_toggle, which flips once per completed byte.
- Reset (rst_n low at an edge) forces:
  - state = IDLE, counter = 0, shift_reg = 0, hold_reg = 0, hold_full = 0.
  - ser_out = 0, ser_valid = 0, frame_start = 0, LED = 3'b000.
  - data_ready = 0 while rst_n is low.
- Reset mid-byte discards both the in-flight byte and the held byte; no partial-byte completion toggle is generated.

## Timing
- Byte accepted at edge E0:
  - hold_full = 1 from E0.
  - If idle, the load occurs at E1; the first bit and frame_start are visible after E1.
  - Bits 2–8 follow after E2–E8; the last bit has counter = 7.
  - Accept-to-first-bit latency: 1 cycle after the accept edge.
- Steady state:
  - Throughput is 1 byte per 8 cycles, with ser_valid continuously high.
  - data_ready reasserts the cycle after each load.
  - A new byte must be accepted at or before the edge preceding the counter == 7 edge to avoid a gap; otherwise ser_valid drops for at least one cycle.
- While the shifter is busy, data_ready is low for the rest of the current byte once the hold buffer is full.
- frame_start is high exactly 1 cycle per byte, coincident with counter == 0.
- LED[0] toggles on the edge that retires counter == 7.

## Test plan
- Reset with data_valid = 1 and rst_n = 0 for 3 cycles:
  - data_ready = 0 throughout.
  - After release: ser_valid = 0, LED = 000, data_ready = 1 on the first cycle.
- Single byte 0xA5, MSB_FIRST = 1, accepted at E0:
  - ser_out = 1,0,1,0,0,1,0,1 over the 8 cycles after E1..E8.
  - frame_start only on the first of those cycles.
  - ser_valid = 0 after E9; LED[0] = 1.
- Back-to-back 0xFF then 0x00 with data_valid held:
  - 16 consecutive ser_valid cycles.
  - frame_start at bits 0 and 8.
  - data_ready low while hold_full; LED[0] toggles twice and returns to 0.
- MSB_FIRST = 0, byte 0x01:
  - ser_out = 1,0,0,0,0,0,0,0.
- Late second byte (accepted at counter == 7):
  - One ser_valid = 0 gap cycle, then the second byte starts with frame_start = 1.
- rst_n low at counter == 4 with hold_full = 1:
  - Next cycle all outputs are 0 and hold_full = 0.
  - No further bits are emitted and LED[0] does not toggle.
